// File: rtl/md_pkg.sv
// Shared encodings and default timing for the multiply/divide sequencer and HI/LO block.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } md_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int CNT_W           = 6;
    localparam int MULT_CYCLES_DEF = 33;
    localparam int DIV_CYCLES_DEF  = 33;

endpackage

// File: rtl/md_cycle_counter.sv
// Up-counter cleared by load; tc flags that the current count equals the last value.
module md_cycle_counter
    import md_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/md_hilo_unit.sv
// Multiply/divide sequencer: holds the unit enable for a fixed cycle count, then captures into HI/LO.
// state | meaning: IDLE wait for start, accept mthi/mtlo | RUN enable held | CAPTURE load HI/LO | DONE done pulse
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic [63:0] mult_result,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    input  logic        div_zero,
    output logic        mult_en,
    output logic        div_en,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    logic             op_q;
    logic             tc;
    logic [CNT_W-1:0] last;

    assign last = (op_q == OP_DIV) ? DIV_LAST : MULT_LAST;

    // Held at zero while idle, so every accepted start begins counting from 0.
    md_cycle_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (state == ST_IDLE),
        .en    (state == ST_RUN),
        .last  (last),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_MULT;
            mult_en <= 1'b0;
            div_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        op_q    <= op;
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        mult_en <= (op == OP_MULT);
                        div_en  <= (op == OP_DIV);
                    end
                end
                ST_RUN: begin
                    if (tc) begin
                        mult_en <= 1'b0;
                        div_en  <= 1'b0;
                        state   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (op_q == OP_MULT) begin
                        hi <= mult_result[63:32];
                        lo <= mult_result[31:0];
                    end else if (!div_zero) begin
                        hi <= div_rem;
                        lo <= div_quot;
                    end else begin
                        div0 <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: directed scenarios plus randomized ops against a HI/LO model.
module tb_md_hilo_unit;

    localparam int N_MULT = 33;
    localparam int N_DIV  = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [63:0] mult_result = '0;
    logic [31:0] div_quot = '0;
    logic [31:0] div_rem = '0;
    logic        div_zero = 1'b0;
    logic        mult_en, div_en, busy, done, div0;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural HI/LO contents.
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    md_hilo_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .mult_result (mult_result),
        .div_quot    (div_quot),
        .div_rem     (div_rem),
        .div_zero    (div_zero),
        .mult_en     (mult_en),
        .div_en      (div_en),
        .busy        (busy),
        .done        (done),
        .div0        (div0),
        .hi          (hi),
        .lo          (lo)
    );

    // Issues one op (start in cycle 0) and measures the 60 cycles that follow.
    // At cycle inject_at a stray start and mtlo are driven; lo is recorded two cycles later.
    task automatic run_op(input logic op_i, input int inject_at,
                          output int en_cnt, output int other_cnt, output int busy_cnt,
                          output int done_at, output int done_cnt, output int div0_cnt,
                          output int div0_wo_done, output int overlap, output logic [31:0] lo_mid);
        en_cnt = 0; other_cnt = 0; busy_cnt = 0; done_at = -1; done_cnt = 0;
        div0_cnt = 0; div0_wo_done = 0; overlap = 0; lo_mid = 'x;
        @(negedge clk);
        start = 1'b1;
        op    = op_i;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (op_i == 1'b0) begin
                if (mult_en) en_cnt++;
                if (div_en) other_cnt++;
            end else begin
                if (div_en) en_cnt++;
                if (mult_en) other_cnt++;
            end
            if (mult_en && div_en) overlap++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (div0) div0_cnt++;
            if (div0 && !done) div0_wo_done++;
            if (c == inject_at + 2) lo_mid = lo;
            start = 1'b0;
            op    = ~op_i;
            mtlo  = 1'b0;
            if (c == inject_at) begin
                start = 1'b1;
                op    = ~op_i;
                mtlo  = 1'b1;
                wdata = $urandom;
            end
        end
        start = 1'b0;
        mtlo  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_hi = '0;
        exp_lo = '0;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        checks++; if ({busy, done, mult_en, div_en, div0} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=%b", {busy, done, mult_en, div_en, div0}, 5'b0);
        end
    endtask

    task automatic test_mult;
        int en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap;
        logic [31:0] lo_mid;
        mult_result = 64'h0000_0001_FFFF_FFFE;
        run_op(1'b0, 1000, en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap, lo_mid);
        exp_hi = 32'h1;
        exp_lo = 32'hFFFF_FFFE;
        checks++; if (en_cnt !== N_MULT) begin errors++; $display("FAIL mult_en_cycles got=%0d exp=%0d", en_cnt, N_MULT); end
        checks++; if (other_cnt !== 0) begin errors++; $display("FAIL mult_div_en got=%0d exp=0", other_cnt); end
        checks++; if (done_at !== N_MULT + 2) begin errors++; $display("FAIL mult_latency got=%0d exp=%0d", done_at, N_MULT + 2); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mult_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_cnt !== N_MULT + 1) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", busy_cnt, N_MULT + 1); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL mult_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_div(input logic zero);
        int en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap;
        logic [31:0] lo_mid;
        div_quot = 32'd7;
        div_rem  = 32'd3;
        div_zero = zero;
        run_op(1'b1, 1000, en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap, lo_mid);
        if (!zero) begin
            exp_hi = 32'd3;
            exp_lo = 32'd7;
        end
        checks++; if (en_cnt !== N_DIV) begin errors++; $display("FAIL div_en_cycles z=%0d got=%0d exp=%0d", zero, en_cnt, N_DIV); end
        checks++; if (other_cnt !== 0) begin errors++; $display("FAIL div_mult_en z=%0d got=%0d exp=0", zero, other_cnt); end
        checks++; if (done_at !== N_DIV + 2 || done_cnt !== 1) begin
            errors++; $display("FAIL div_done z=%0d at=%0d cnt=%0d exp_at=%0d exp_cnt=1", zero, done_at, done_cnt, N_DIV + 2);
        end
        checks++; if (div0_cnt !== int'(zero) || d0wd !== 0) begin
            errors++; $display("FAIL div0_pulse z=%0d got=%0d stray=%0d exp=%0d", zero, div0_cnt, d0wd, int'(zero));
        end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL div_hilo z=%0d got=%h_%h exp=%h_%h", zero, hi, lo, exp_hi, exp_lo);
        end
        div_zero = 1'b0;
    endtask

    task automatic test_move;
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL mthi got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo);
        end
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        exp_hi = 32'h1234_5678;
        exp_lo = 32'h1234_5678;
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL mthi_mtlo_both got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_start_with_write;
        int c;
        mult_result = 64'hAAAA_5555_0F0F_F0F0;
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
        checks++; if (lo !== 32'hCAFE_0001 || mult_en !== 1'b1) begin
            errors++; $display("FAIL start_with_mtlo lo=%h mult_en=%b exp lo=%h mult_en=1", lo, mult_en, 32'hCAFE_0001);
        end
        c = 1;
        while (done !== 1'b1 && c < 80) begin
            @(negedge clk);
            c++;
        end
        exp_hi = 32'hAAAA_5555;
        exp_lo = 32'h0F0F_F0F0;
        checks++; if (c !== N_MULT + 2 || hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL capture_overwrites at=%0d hilo=%h_%h exp at=%0d hilo=%h_%h", c, hi, lo, N_MULT + 2, exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_during_run;
        int en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap;
        logic [31:0] lo_mid;
        mult_result = 64'h1111_2222_3333_4444;
        run_op(1'b0, 12, en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap, lo_mid);
        checks++; if (lo_mid !== exp_lo) begin errors++; $display("FAIL mtlo_in_run lo=%h exp=%h", lo_mid, exp_lo); end
        exp_hi = 32'h1111_2222;
        exp_lo = 32'h3333_4444;
        checks++; if (done_cnt !== 1 || done_at !== N_MULT + 2 || en_cnt !== N_MULT || other_cnt !== 0) begin
            errors++; $display("FAIL start_in_run done_cnt=%0d at=%0d en=%0d other=%0d exp 1/%0d/%0d/0",
                               done_cnt, done_at, en_cnt, other_cnt, N_MULT + 2, N_MULT);
        end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL run_ignore_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo);
        end
        // A start held in the done cycle must also be dropped.
        run_op(1'b1, N_DIV + 2, en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap, lo_mid);
        exp_hi = div_rem;
        exp_lo = div_quot;
        checks++; if (done_cnt !== 1 || busy_cnt !== N_DIV + 1) begin
            errors++; $display("FAIL start_in_done done_cnt=%0d busy=%0d exp 1/%0d", done_cnt, busy_cnt, N_DIV + 1);
        end
    endtask

    task automatic test_reset_mid_op;
        int done_cnt;
        mult_result = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_hi = '0;
        exp_lo = '0;
        checks++; if ({busy, done, mult_en, div_en, div0} !== 5'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL reset_mid_op ctrl=%b hilo=%h_%h exp ctrl=0 hilo=0", {busy, done, mult_en, div_en, div0}, hi, lo);
        end
        reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || mult_en) done_cnt++;
        end
        checks++; if (done_cnt !== 0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL abort_no_capture activity=%0d hilo=%h_%h exp 0 %h_%h", done_cnt, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_random;
        int en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap, n;
        logic [31:0] lo_mid;
        logic r_op, r_zero;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mthi  = 1'($urandom_range(0, 1));
            mtlo  = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if (mthi) exp_hi = wdata;
            if (mtlo) exp_lo = wdata;
            @(negedge clk);
            mthi = 1'b0;
            mtlo = 1'b0;
            checks++; if (hi !== exp_hi || lo !== exp_lo) begin
                errors++; $display("FAIL rnd_move i=%0d got=%h_%h exp=%h_%h", i, hi, lo, exp_hi, exp_lo);
            end
            r_op        = 1'($urandom_range(0, 1));
            r_zero      = ($urandom_range(0, 3) == 0);
            mult_result = {$urandom, $urandom};
            div_quot    = $urandom;
            div_rem     = $urandom;
            div_zero    = r_zero;
            run_op(r_op, 1000, en_cnt, other_cnt, busy_cnt, done_at, done_cnt, div0_cnt, d0wd, overlap, lo_mid);
            if (!r_op) begin
                exp_hi = mult_result[63:32];
                exp_lo = mult_result[31:0];
            end else if (!r_zero) begin
                exp_hi = div_rem;
                exp_lo = div_quot;
            end
            n = r_op ? N_DIV : N_MULT;
            checks++; if (en_cnt !== n || other_cnt !== 0 || overlap !== 0 || done_at !== n + 2 || done_cnt !== 1) begin
                errors++; $display("FAIL rnd_timing i=%0d op=%0d en=%0d other=%0d ovl=%0d at=%0d cnt=%0d exp en=%0d at=%0d",
                                   i, r_op, en_cnt, other_cnt, overlap, done_at, done_cnt, n, n + 2);
            end
            checks++; if (div0_cnt !== int'(r_op && r_zero) || d0wd !== 0) begin
                errors++; $display("FAIL rnd_div0 i=%0d got=%0d exp=%0d", i, div0_cnt, int'(r_op && r_zero));
            end
            checks++; if (hi !== exp_hi || lo !== exp_lo) begin
                errors++; $display("FAIL rnd_hilo i=%0d op=%0d z=%0d got=%h_%h exp=%h_%h", i, r_op, r_zero, hi, lo, exp_hi, exp_lo);
            end
            div_zero = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div(1'b0);
        test_div(1'b1);
        test_move();
        test_start_with_write();
        test_ignore_during_run();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
